// File: rtl/varredura_matriz_if.sv
// Frame-source and matrix-drive bundle for the 5x7 LED scanner.
//   en           : scan enable (0 blanks the matrix)
//   sel          : frame source, 1 = padrao_rega, 0 = padrao_caixa
//   padrao_rega  : irrigation bitmap, bit c*7+r = row r of column c
//   padrao_caixa : water-tank bitmap, same mapping
//   col          : column drive, active-low one-hot
//   l            : row drive, active-high
//   fim_quadro   : end-of-frame strobe
interface varredura_matriz_if;
    logic        en;
    logic        sel;
    logic [34:0] padrao_rega;
    logic [34:0] padrao_caixa;
    logic [4:0]  col;
    logic [6:0]  l;
    logic        fim_quadro;

    modport master (
        output en, sel, padrao_rega, padrao_caixa,
        input  col, l, fim_quadro
    );

    modport slave (
        input  en, sel, padrao_rega, padrao_caixa,
        output col, l, fim_quadro
    );
endinterface

// File: rtl/varredura_matriz.sv
// 5x7 LED matrix column scanner. Each column stays active for DIV clk
// cycles; the frame buffer is latched at scan start and on every 4->0
// column wrap, so pattern/select changes only show from the next frame.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of varredura_matriz_if (inputs, col/l/fim_quadro)
module varredura_matriz #(
    parameter int unsigned DIV = 50000
) (
    input  logic               clk,
    input  logic               reset,
    varredura_matriz_if.slave  bus
);

    localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'd4;

    typedef enum logic {
        DESLIGADO = 1'b0,
        VARRENDO  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [34:0]        frame_buf_q, frame_buf_d;
    logic [34:0]        padrao_sel;

    assign padrao_sel = bus.sel ? bus.padrao_rega : bus.padrao_caixa;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DESLIGADO;
            idx_q       <= 3'd0;
            presc_q     <= '0;
            frame_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            presc_q     <= presc_d;
            frame_buf_q <= frame_buf_d;
        end
    end

    // Next-state and matrix decode
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        presc_d        = presc_q;
        frame_buf_d    = frame_buf_q;
        bus.col        = 5'b11111;
        bus.l          = 7'b0000000;
        bus.fim_quadro = 1'b0;

        case (state_q)
            DESLIGADO: begin
                idx_d   = 3'd0;
                presc_d = '0;
                if (bus.en) begin
                    state_d     = VARRENDO;
                    frame_buf_d = padrao_sel;
                end
            end

            VARRENDO: begin
                // Case decode guarantees a single active column.
                case (idx_q)
                    3'd0: begin bus.col = 5'b11110; bus.l = frame_buf_q[6:0];   end
                    3'd1: begin bus.col = 5'b11101; bus.l = frame_buf_q[13:7];  end
                    3'd2: begin bus.col = 5'b11011; bus.l = frame_buf_q[20:14]; end
                    3'd3: begin bus.col = 5'b10111; bus.l = frame_buf_q[27:21]; end
                    3'd4: begin bus.col = 5'b01111; bus.l = frame_buf_q[34:28]; end
                    default: begin bus.col = 5'b11111; bus.l = 7'b0000000; end
                endcase

                bus.fim_quadro = (idx_q == IDX_LAST) && (presc_q == PRESC_MAX);

                if (!bus.en) begin
                    state_d = DESLIGADO;
                    idx_d   = 3'd0;
                    presc_d = '0;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d       = 3'd0;
                        frame_buf_d = padrao_sel;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end

            default: begin
                state_d = DESLIGADO;
                idx_d   = 3'd0;
                presc_d = '0;
            end
        endcase
    end

endmodule
